seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_if.sv | 29 ++
 rtl/seq_divider.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seq_divider_if.sv
// Request/response bundle for seq_divider: operand request with start/ready,
// result with valid_out/out_ready plus quotient, remainder and status flags.
interface seq_divider_if #(
  parameter int unsigned N = 32
);
  logic         start;
  logic         ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         is_signed;
  logic         valid_out;
  logic         out_ready;
  logic [N-1:0] q;
  logic [N-1:0] r;
  logic         dz;
  logic         v;
  logic         z_;
  logic         n;

  modport master (
    output start, a, b, is_signed, out_ready,
    input  ready, valid_out, q, r, dz, v, z_, n
  );

  modport slave (
    input  start, a, b, is_signed, out_ready,
    output ready, valid_out, q, r, dz, v, z_, n
  );
endinterface

// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider, signed or unsigned, one quotient bit per
// cycle, with divide-by-zero and signed-overflow shortcuts and a held result.
module seq_divider #(
  parameter int unsigned N = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_divider_if.slave    bus
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic [N-1:0]    r_rem;
  logic [N-1:0]    r_dvd;
  logic [N-1:0]    r_dvs;
  logic [N-1:0]    r_quo;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_sdz;
  logic            r_sov;
  logic            r_pend;
  logic            r_ready;
  logic            r_valid;
  logic [N-1:0]    r_q;
  logic [N-1:0]    r_r;
  logic            r_dz;
  logic            r_v;
  logic            r_z;
  logic            r_n;

  logic [N-1:0]    w_a_mag;
  logic [N-1:0]    w_b_mag;
  logic            w_b_zero;
  logic            w_ovf_req;
  logic [N:0]      w_rem_sh;
  logic [N-1:0]    w_diff;
  logic            w_fit;
  logic [N-1:0]    w_q_fin;
  logic [N-1:0]    w_r_fin;

  assign w_a_mag   = (bus.is_signed && bus.a[N-1]) ? -bus.a : bus.a;
  assign w_b_mag   = (bus.is_signed && bus.b[N-1]) ? -bus.b : bus.b;
  assign w_b_zero  = (bus.b == '0);
  assign w_ovf_req = bus.is_signed && (bus.a == {1'b1, {(N-1){1'b0}}}) && (bus.b == '1);

  // N+1-bit partial remainder; the difference fits in N bits whenever it is kept.
  assign w_rem_sh  = {r_rem, r_dvd[N-1]};
  assign w_fit     = (w_rem_sh >= {1'b0, r_dvs});
  assign w_diff    = w_rem_sh[N-1:0] - r_dvs;

  always_comb begin
    w_q_fin = r_neg_q ? -r_quo : r_quo;
    w_r_fin = r_neg_r ? -r_rem : r_rem;
    if (r_sdz) begin
      w_q_fin = '1;
      w_r_fin = r_dvd;
    end else if (r_sov) begin
      w_q_fin = {1'b1, {(N-1){1'b0}}};
      w_r_fin = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_quo   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_sdz   <= 1'b0;
      r_sov   <= 1'b0;
      r_pend  <= 1'b0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
      r_dz    <= 1'b0;
      r_v     <= 1'b0;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_ready <= 1'b0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_dvd   <= w_b_zero ? bus.a : w_a_mag;
            r_dvs   <= w_b_mag;
            r_neg_q <= bus.is_signed & (bus.a[N-1] ^ bus.b[N-1]);
            r_neg_r <= bus.is_signed & bus.a[N-1];
            r_sdz   <= w_b_zero;
            r_sov   <= w_ovf_req;
            if (w_b_zero || w_ovf_req) begin
              r_state <= StDone;
              r_pend  <= 1'b1;
            end else begin
              r_state <= StCalc;
            end
          end
        end
        StCalc: begin
          r_rem <= w_fit ? w_diff : w_rem_sh[N-1:0];
          r_quo <= {r_quo[N-2:0], w_fit};
          r_dvd <= {r_dvd[N-2:0], 1'b0};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CntW'(N - 1)) begin
            r_state <= StDone;
            r_pend  <= 1'b1;
          end
        end
        StDone: begin
          // First DONE cycle applies sign fix-up and registers the result.
          if (r_pend) begin
            r_pend  <= 1'b0;
            r_valid <= 1'b1;
            r_q     <= w_q_fin;
            r_r     <= w_r_fin;
            r_dz    <= r_sdz;
            r_v     <= r_sov;
            r_z     <= (w_q_fin == '0);
            r_n     <= w_q_fin[N-1];
          end else if (bus.out_ready) begin
            r_state <= StIdle;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_q     <= '0;
            r_r     <= '0;
            r_dz    <= 1'b0;
            r_v     <= 1'b0;
            r_z     <= 1'b0;
            r_n     <= 1'b0;
          end
        end
        default: begin
          r_state <= StIdle;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready     = r_ready;
  assign bus.valid_out = r_valid;
  assign bus.q         = r_q;
  assign bus.r         = r_r;
  assign bus.dz        = r_dz;
  assign bus.v         = r_v;
  assign bus.z_        = r_z;
  assign bus.n         = r_n;

endmodule
